mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 33 +++
 rtl/mdu_ctrl.sv | 153 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: bundles the EX-stage request/result signals and the external
// divider handshake seen by the multiply/divide controller.
// The master side is the environment (pipeline plus divider); the slave side
// is the controller itself.
interface mdu_ctrl_if;
    // Pipeline side
    logic        valid;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    // Divider side
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opr1;
    logic [31:0] div_opr2;
    logic        div_abandon;
    logic        div_ready;
    logic [63:0] div_res;

    modport master (
        output valid, op, opa, opb, flush, div_ready, div_res,
        input  stall, hi, lo, div_start, div_signed, div_opr1, div_opr2, div_abandon
    );

    modport slave (
        input  valid, op, opa, opb, flush, div_ready, div_res,
        output stall, hi, lo, div_start, div_signed, div_opr1, div_opr2, div_abandon
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: owns the architectural HI/LO registers, runs MULT/MULTU as a
// one-cycle operation, and sequences DIV/DIVU through an external divider.
// The pipeline is held via a combinational stall while an operation is busy.
module mdu_ctrl (
    input  logic      clk,
    input  logic      rst,
    mdu_ctrl_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_signed_q, mul_signed_d;
    logic        div_start_q, div_start_d;
    logic        div_signed_q, div_signed_d;
    logic [31:0] div_opr1_q, div_opr1_d;
    logic [31:0] div_opr2_q, div_opr2_d;

    logic        is_mul_op;
    logic        is_div_op;
    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] mul_product;

    assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    // Sign- or zero-extend the latched operands to 64 bits so the low 64 bits
    // of a plain product are correct for both MULT and MULTU.
    assign mul_ext_a   = {{32{mul_signed_q & mul_a_q[31]}}, mul_a_q};
    assign mul_ext_b   = {{32{mul_signed_q & mul_b_q[31]}}, mul_b_q};
    assign mul_product = mul_ext_a * mul_ext_b;

    // Stall while a multiply/divide is being issued or the divider is still busy;
    // never while flushing or held in reset.
    assign bus.stall = rst & ~bus.flush &
                       (((state_q == S_IDLE) & bus.valid & (is_mul_op | is_div_op)) |
                        ((state_q == S_DIV) & ~bus.div_ready));

    assign bus.div_abandon = bus.flush;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_start   = div_start_q;
    assign bus.div_signed  = div_signed_q;
    assign bus.div_opr1    = div_opr1_q;
    assign bus.div_opr2    = div_opr2_q;

    // Next-state and next-register computation for the whole controller.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        div_start_d  = div_start_q;
        div_signed_d = div_signed_q;
        div_opr1_d   = div_opr1_q;
        div_opr2_d   = div_opr2_q;

        if (bus.flush) begin
            // Flush kills everything in flight and suppresses any HI/LO write.
            state_d     = S_IDLE;
            div_start_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                mul_a_d      = bus.opa;
                                mul_b_d      = bus.opb;
                                mul_signed_d = (bus.op == OP_MULT);
                                state_d      = S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                div_opr1_d   = bus.opa;
                                div_opr2_d   = bus.opb;
                                div_signed_d = (bus.op == OP_DIV);
                                div_start_d  = 1'b1;
                                state_d      = S_DIV;
                            end
                            OP_MTHI: hi_d = bus.opa;
                            OP_MTLO: lo_d = bus.opa;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    hi_d    = mul_product[63:32];
                    lo_d    = mul_product[31:0];
                    state_d = S_IDLE;
                end
                S_DIV: begin
                    // Request and operands stay frozen until the divider answers.
                    if (bus.div_ready) begin
                        hi_d        = bus.div_res[63:32];
                        lo_d        = bus.div_res[31:0];
                        div_start_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    div_start_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            div_start_q  <= 1'b0;
            div_signed_q <= 1'b0;
            div_opr1_q   <= '0;
            div_opr2_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            div_start_q  <= div_start_d;
            div_signed_q <= div_signed_d;
            div_opr1_q   <= div_opr1_d;
            div_opr2_q   <= div_opr2_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a behavioural divider and a
// scoreboard of expected HI/LO values.
module tb_mdu_ctrl;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv_ready = 1'b0;
    logic [63:0] dv_res = '0;
    int          div_lat = 4;
    int          div_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] ref_r;

    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.div_ready = dv_ready;
    assign bus.div_res   = dv_res;

    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        int          sa;
        int          sb;
        int unsigned ua;
        int unsigned ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        ua = a;
        ub = b;
        return {ua % ub, ua / ub};
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint la;
        longint lb;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'h0, a});
            lb = longint'({32'h0, b});
        end
        return 64'(la * lb);
    endfunction

    // Divider: answers div_latency negedges after it first sees div_start,
    // holds ready for one cycle, and forgets a request once div_start drops.
    always @(negedge clk) begin
        if (!bus.div_start || dv_ready) begin
            dv_ready = 1'b0;
            div_cnt  = 0;
        end else begin
            div_cnt++;
            if (div_cnt >= div_lat) begin
                dv_ready = 1'b1;
                dv_res   = div_model(bus.div_opr1, bus.div_opr2, bus.div_signed);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.tag = tag;
        e.hi  = hi;
        e.lo  = lo;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_hi"}, bus.hi, e.hi);
            check({e.tag, "_lo"}, bus.lo, e.lo);
            model_hi = e.hi;
            model_lo = e.lo;
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        bus.valid = v;
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
    endtask

    // Each task starts just after a falling edge and returns just after one.
    task automatic run_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo, input string tag);
        push(tag, hi, lo);
        drive(1'b1, o, a, b);
        #1 check({tag, "_stall_issue"}, bus.stall, 1);
        @(negedge clk);
        #1 check({tag, "_stall_mul"}, bus.stall, 0);
        drive(1'b0, OP_NOP, '0, '0);
        @(negedge clk);
        #1 sb_check();
    endtask

    task automatic run_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo, input string tag);
        logic seen;
        logic sgn_exp;
        sgn_exp = (o == OP_DIV);
        seen    = 1'b0;
        push(tag, hi, lo);
        drive(1'b1, o, a, b);
        #1 check({tag, "_stall_issue"}, bus.stall, 1);
        check({tag, "_start_gap"}, bus.div_start, 0);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.div_ready) begin
                seen = 1'b1;
            end else begin
                check({tag, "_start_hold"}, {bus.div_start, bus.div_signed}, {1'b1, sgn_exp});
                check({tag, "_opr_hold"}, {bus.div_opr1, bus.div_opr2}, {a, b});
                check({tag, "_stall_busy"}, bus.stall, 1);
            end
        end
        check({tag, "_ready_seen"}, seen, 1);
        check({tag, "_stall_ready"}, bus.stall, 0);
        drive(1'b0, OP_NOP, '0, '0);
        @(negedge clk);
        #1 check({tag, "_start_low"}, bus.div_start, 0);
        sb_check();
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] val, input string tag);
        if (o == OP_MTHI) push(tag, val, model_lo);
        else push(tag, model_hi, val);
        drive(1'b1, o, val, 32'hDEAD_BEEF);
        #1 check({tag, "_stall"}, bus.stall, 0);
        @(negedge clk);
        drive(1'b0, OP_NOP, '0, '0);
        #1 sb_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.flush = 1'b0;
        drive(1'b1, OP_MULT, 32'h5, 32'h7);
        rst = 1'b0;

        // Reset state, with a multiply request present that must not stall.
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_div_ctl", {bus.div_start, bus.div_signed}, 0);
        check("rst_div_opr", {bus.div_opr1, bus.div_opr2}, 64'd0);
        drive(1'b0, OP_NOP, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Reserved op code behaves as a NOP.
        drive(1'b1, OP_RSVD, 32'hAAAA_5555, 32'h1234_0000);
        #1 check("op7_stall", bus.stall, 0);
        @(negedge clk);
        drive(1'b0, OP_NOP, '0, '0);
        #1 check("op7_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

        run_mul(OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        run_mul(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu_big");
        ref_r = ref_mul(32'h8000_0000, 32'h8000_0001, 1'b1);
        run_mul(OP_MULT,  32'h8000_0000, 32'h8000_0001, ref_r[63:32], ref_r[31:0], "mult_min");

        div_lat = 4;
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");

        // Flush five cycles into a long divide.
        div_lat = 20;
        drive(1'b1, OP_DIVU, 32'd50, 32'd5);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("fl_abandon", bus.div_abandon, 1);
        check("fl_stall", bus.stall, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b0, OP_NOP, '0, '0);
        #1;
        check("fl_start_low", bus.div_start, 0);
        check("fl_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

        div_lat = 4;
        run_div(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");

        // Flush arriving in the same cycle as div_ready: flush wins.
        div_lat = 3;
        drive(1'b1, OP_DIV, 32'd40, 32'd6);
        repeat (3) @(negedge clk);
        #1 check("fr_ready_present", bus.div_ready, 1);
        bus.flush = 1'b1;
        #1 check("fr_stall", bus.stall, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b0, OP_NOP, '0, '0);
        #1;
        check("fr_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});
        check("fr_start_low", bus.div_start, 0);

        // Moves, then two divides back to back.
        run_mt(OP_MTHI, 32'h1234_5678, "mthi");
        run_mt(OP_MTLO, 32'h9ABC_DEF0, "mtlo");
        div_lat = 2;
        run_div(OP_DIV, 32'd20, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFA, "div_b2b_a");
        run_div(OP_DIV, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_b2b_b");

        // Divide by zero: HI/LO take whatever the divider returns.
        run_div(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "div_zero");

        // Asynchronous reset in the middle of a divide.
        div_lat = 20;
        drive(1'b1, OP_DIV, 32'd77, 32'd5);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("arst_div_ctl", {bus.div_start, bus.div_signed}, 0);
        check("arst_div_opr", {bus.div_opr1, bus.div_opr2}, 64'd0);
        check("arst_stall", bus.stall, 0);
        drive(1'b0, OP_NOP, '0, '0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;

        run_mul(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, "post_rst_multu");

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
